detector_jogada: RTL



---
 rtl/detector_jogada.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/detector_jogada.sv
`default_nettype none
// ============================================================================
//  Module   : detector_jogada
//  Purpose  : Player-button input stage for the sequence game. Synchronises
//             and debounces the four buttons, emits a one-cycle jogada_feita
//             strobe with a registered 4-bit play code, and owns the play
//             timeout counter.
//  Option   : DETECTOR_JOGADA_REJEITA_MULTIPLA_EN -- when defined, only
//             one-hot button patterns can become a play.
//  Revision : 1.0 - initial release
// ============================================================================
module detector_jogada #(
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int TIMEOUT_CICLOS  = 5000,
    parameter int TIMEOUT_LARGURA = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       conta_timeout,
    input  logic       zera_timeout,
    output logic       jogada_feita,
    output logic [3:0] jogada,
    output logic       tem_jogada,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam int                     DW      = $clog2(DEBOUNCE_CICLOS) + 1;
    localparam logic [DW-1:0]          DEB_FIM = DW'(DEBOUNCE_CICLOS - 1);
    localparam logic [TIMEOUT_LARGURA-1:0] TO_FIM = TIMEOUT_LARGURA'(TIMEOUT_CICLOS - 1);

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        FILTRO  = 2'd1,
        ACEITO  = 2'd2,
        SOLTURA = 2'd3
    } estado_t;

    estado_t                    state;
    estado_t                    state_next;
    logic [3:0]                 sinc_meta;
    logic [3:0]                 sinc;
    logic [3:0]                 candidate;
    logic [3:0]                 candidate_next;
    logic [DW-1:0]              cnt_deb;
    logic [DW-1:0]              cnt_deb_next;
    logic [3:0]                 jogada_next;
    logic [TIMEOUT_LARGURA-1:0] cnt_to;
    logic [TIMEOUT_LARGURA-1:0] cnt_to_inc;
    logic                       aceita_padrao;

    // A pattern may start a debounce only if it is a legal play.
`ifdef DETECTOR_JOGADA_REJEITA_MULTIPLA_EN
    assign aceita_padrao = (sinc != 4'd0) && ((sinc & (sinc - 4'd1)) == 4'd0);
`else
    assign aceita_padrao = (sinc != 4'd0);
`endif

    assign jogada_feita = (state == ACEITO);
    assign db_estado    = {2'b00, state};
    assign cnt_to_inc   = cnt_to + TIMEOUT_LARGURA'(1);

    // Two-flop synchroniser on the raw buttons, plus the "any button" level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc_meta  <= 4'd0;
            sinc       <= 4'd0;
            tem_jogada <= 1'b0;
        end else begin
            sinc_meta  <= botoes;
            sinc       <= sinc_meta;
            tem_jogada <= (sinc != 4'd0);
        end
    end

    // FSM and debounce datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ESPERA;
            candidate <= 4'd0;
            cnt_deb   <= '0;
            jogada    <= 4'd0;
        end else begin
            state     <= state_next;
            candidate <= candidate_next;
            cnt_deb   <= cnt_deb_next;
            jogada    <= jogada_next;
        end
    end

    // Next-state logic: press filter, single-cycle accept, release filter.
    always_comb begin
        state_next     = state;
        candidate_next = candidate;
        cnt_deb_next   = cnt_deb;
        jogada_next    = jogada;
        case (state)
            ESPERA: begin
                if (aceita_padrao) begin
                    candidate_next = sinc;
                    cnt_deb_next   = '0;
                    state_next     = FILTRO;
                end
            end
            FILTRO: begin
                // Any deviation (glitch, release, new pattern) aborts the press.
                if (sinc != candidate) begin
                    state_next = ESPERA;
                end else if (cnt_deb == DEB_FIM) begin
                    jogada_next = candidate;
                    state_next  = ACEITO;
                end else begin
                    cnt_deb_next = cnt_deb + DW'(1);
                end
            end
            ACEITO: begin
                cnt_deb_next = '0;
                state_next   = SOLTURA;
            end
            SOLTURA: begin
                // Only a full run of released cycles re-arms the detector.
                if (sinc != 4'd0) begin
                    cnt_deb_next = '0;
                end else if (cnt_deb == DEB_FIM) begin
                    cnt_deb_next = '0;
                    state_next   = ESPERA;
                end else begin
                    cnt_deb_next = cnt_deb + DW'(1);
                end
            end
            default: begin
                state_next = ESPERA;
            end
        endcase
    end

    // Saturating play-timeout counter with a sticky flag; clear has priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_to  <= '0;
            timeout <= 1'b0;
        end else if (zera_timeout) begin
            cnt_to  <= '0;
            timeout <= 1'b0;
        end else if (jogada_feita) begin
            cnt_to <= '0;
        end else if (conta_timeout && (cnt_to != TO_FIM)) begin
            cnt_to <= cnt_to_inc;
            if (cnt_to_inc == TO_FIM) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
